pcm_loopback_checker: RTL and testbench

- Sits downstream of the FSK system top level and consumes its two 8-bit sample streams: transmitted samples (datain) and recovered samples (dataout).
- Automatically finds the end-to-end loopback latency in sample periods.
- Locks onto that latency, then counts compared samples and sample errors.
- Provides the built-in figure-of-merit for the FSK link on board and in simulation.

---
 rtl/pcm_loopback_checker.sv | 149 ++++++++++++++
 tb/tb_pcm_loopback_checker.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_loopback_checker.sv
// PCM loopback checker: searches for the tx->rx latency, locks to it,
// then counts compared samples and sample errors.
module pcm_loopback_checker #(
    parameter int MAX_LAT = 16,
    parameter int LAT_W   = 4,
    parameter int LOCK_N  = 8,
    parameter int LOSS_N  = 4,
    parameter int TOL     = 2,
    parameter int CW      = 16
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [7:0]       tx_data,
    input  logic [7:0]       rx_data,
    input  logic             clear,
    output logic             locked,
    output logic [LAT_W-1:0] lat,
    output logic [CW-1:0]    sample_cnt,
    output logic [CW-1:0]    err_cnt,
    output logic             cnt_sat
);

    localparam int RUN_W  = $clog2(LOCK_N + 1);
    localparam int MISS_W = $clog2(LOSS_N + 1);
    localparam int HD     = MAX_LAT - 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_N - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_N - 1);
    localparam logic [LAT_W-1:0]  FILL_MAX  = LAT_W'(MAX_LAT - 1);
    localparam logic [CW-1:0]     CMAX      = '1;
    localparam logic [CW-1:0]     CNEAR     = {{(CW-1){1'b1}}, 1'b0};

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    state_t            state, state_d;
    logic [LAT_W-1:0]  lat_d;
    logic [LAT_W-1:0]  fill, fill_d;
    logic [RUN_W-1:0]  run, run_d;
    logic [MISS_W-1:0] miss, miss_d;
    logic [CW-1:0]     sample_cnt_d, err_cnt_d;
    logic              cnt_sat_d;
    logic [7:0]        hist [HD];

    logic [7:0] ref_s;
    logic [8:0] diff, adiff;
    logic       ref_valid, match;

    // Reference tap: lat=0 compares against the live tx sample.
    always_comb begin
        ref_s = tx_data;
        for (int k = 1; k < MAX_LAT; k++) begin
            if (lat == LAT_W'(k)) ref_s = hist[k-1];
        end
    end

    assign diff      = {1'b0, ref_s} - {1'b0, rx_data};
    assign adiff     = diff[8] ? (~diff + 9'd1) : diff;
    assign ref_valid = (lat <= fill);
    assign match     = ref_valid && (adiff <= 9'(TOL));
    assign locked    = (state == LOCKED);

    always_comb begin
        state_d      = state;
        lat_d        = lat;
        fill_d       = fill;
        run_d        = run;
        miss_d       = miss;
        sample_cnt_d = sample_cnt;
        err_cnt_d    = err_cnt;
        cnt_sat_d    = cnt_sat;
        if (sample_en) begin
            if (fill != FILL_MAX) fill_d = fill + 1'b1;
            unique case (state)
                SEARCH: begin
                    if (match && run == RUN_LAST) begin
                        state_d      = LOCKED;
                        run_d        = '0;
                        sample_cnt_d = '0;
                        err_cnt_d    = '0;
                        cnt_sat_d    = 1'b0;
                    end else if (match) begin
                        run_d = run + 1'b1;
                    end else begin
                        run_d = '0;
                        lat_d = lat + 1'b1;
                    end
                end
                LOCKED: begin
                    if (sample_cnt != CMAX) begin
                        sample_cnt_d = sample_cnt + 1'b1;
                        if (sample_cnt == CNEAR) cnt_sat_d = 1'b1;
                    end
                    if (match) begin
                        miss_d = '0;
                    end else begin
                        if (err_cnt != CMAX) begin
                            err_cnt_d = err_cnt + 1'b1;
                            if (err_cnt == CNEAR) cnt_sat_d = 1'b1;
                        end
                        if (miss == MISS_LAST) begin
                            state_d = SEARCH;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss + 1'b1;
                        end
                    end
                end
            endcase
        end
        // Clear only touches the statistics, never the lock machinery.
        if (clear) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            cnt_sat_d    = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state      <= SEARCH;
            lat        <= '0;
            fill       <= '0;
            run        <= '0;
            miss       <= '0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            cnt_sat    <= 1'b0;
            for (int k = 0; k < HD; k++) hist[k] <= '0;
        end else begin
            state      <= state_d;
            lat        <= lat_d;
            fill       <= fill_d;
            run        <= run_d;
            miss       <= miss_d;
            sample_cnt <= sample_cnt_d;
            err_cnt    <= err_cnt_d;
            cnt_sat    <= cnt_sat_d;
            if (sample_en) begin
                hist[0] <= tx_data;
                for (int k = 1; k < HD; k++) hist[k] <= hist[k-1];
            end
        end
    end

endmodule

// File: tb/tb_pcm_loopback_checker.sv
// Bench for pcm_loopback_checker: directed stream phases checked
// against a queue-based behavioural model plus literal expectations.
module tb_pcm_loopback_checker;

    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_en = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] tx_data = '0;
    logic [7:0] rx_data = '0;

    logic        locked, locked4;
    logic [3:0]  lat, lat4;
    logic [15:0] sample_cnt, err_cnt;
    logic [3:0]  sc4, ec4;
    logic        cnt_sat, sat4;

    always #5 sysclk = ~sysclk;

    pcm_loopback_checker dut (
        .sysclk(sysclk), .reset(reset), .sample_en(sample_en),
        .tx_data(tx_data), .rx_data(rx_data), .clear(clear),
        .locked(locked), .lat(lat), .sample_cnt(sample_cnt),
        .err_cnt(err_cnt), .cnt_sat(cnt_sat)
    );

    pcm_loopback_checker #(.CW(4)) dut4 (
        .sysclk(sysclk), .reset(reset), .sample_en(sample_en),
        .tx_data(tx_data), .rx_data(rx_data), .clear(clear),
        .locked(locked4), .lat(lat4), .sample_cnt(sc4),
        .err_cnt(ec4), .cnt_sat(sat4)
    );

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: latency search over a plain history queue.
    bit         m_locked;
    int         m_lat, m_run, m_miss;
    int         m_sc, m_ec, m_sc4, m_ec4;
    bit         m_sat, m_sat4;
    logic [7:0] m_hist[$];

    task automatic mreset();
        m_locked = 0; m_lat = 0; m_run = 0; m_miss = 0;
        m_sc = 0; m_ec = 0; m_sat = 0;
        m_sc4 = 0; m_ec4 = 0; m_sat4 = 0;
        m_hist.delete();
    endtask

    task automatic sinc(inout int c, inout bit s, input int cap);
        if (c < cap) begin
            c++;
            if (c == cap) s = 1;
        end
    endtask

    task automatic mstep(bit en, logic [7:0] t, logic [7:0] r, bit clr);
        logic [7:0] refv;
        int d;
        bit m;
        if (en) begin
            refv = (m_lat == 0) ? t : m_hist[m_lat-1];
            d = int'(refv) - int'(r);
            if (d < 0) d = -d;
            m = (m_lat <= m_hist.size()) && (d <= 2);
            if (!m_locked) begin
                if (m && m_run == 7) begin
                    m_locked = 1; m_run = 0;
                    m_sc = 0; m_ec = 0; m_sat = 0;
                    m_sc4 = 0; m_ec4 = 0; m_sat4 = 0;
                end else if (m) begin
                    m_run++;
                end else begin
                    m_run = 0;
                    m_lat = (m_lat + 1) % 16;
                end
            end else begin
                sinc(m_sc, m_sat, 65535);
                sinc(m_sc4, m_sat4, 15);
                if (m) begin
                    m_miss = 0;
                end else begin
                    sinc(m_ec, m_sat, 65535);
                    sinc(m_ec4, m_sat4, 15);
                    m_miss++;
                    if (m_miss == 4) begin
                        m_locked = 0;
                        m_miss = 0;
                    end
                end
            end
            m_hist.push_front(t);
            if (m_hist.size() > 15) void'(m_hist.pop_back());
        end
        if (clr) begin
            m_sc = 0; m_ec = 0; m_sat = 0;
            m_sc4 = 0; m_ec4 = 0; m_sat4 = 0;
        end
    endtask

    always @(negedge sysclk) begin
        if (chk_on) begin
            cmp("locked", locked, m_locked);
            cmp("lat", lat, m_lat);
            cmp("sample_cnt", sample_cnt, m_sc);
            cmp("err_cnt", err_cnt, m_ec);
            cmp("cnt_sat", cnt_sat, m_sat);
            cmp("locked4", locked4, m_locked);
            cmp("lat4", lat4, m_lat);
            cmp("sample_cnt4", sc4, m_sc4);
            cmp("err_cnt4", ec4, m_ec4);
            cmp("cnt_sat4", sat4, m_sat4);
        end
    end

    // Stimulus stream: LFSR tx and a 5-deep delay line for rx.
    logic [7:0] lfsr;
    logic [7:0] dly[$];

    task automatic restart();
        lfsr = 8'hA5;
        dly.delete();
        repeat (5) dly.push_front(8'h00);
    endtask

    task automatic drive(bit en, logic [7:0] t, logic [7:0] r, bit clr);
        @(negedge sysclk);
        sample_en = en;
        tx_data = t;
        rx_data = r;
        clear = clr;
        @(posedge sysclk);
        mstep(en, t, r, clr);
    endtask

    task automatic sample(int off, bit bad, bit clr);
        logic [7:0] t, d, r;
        int v;
        t = lfsr;
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        d = dly.pop_back();
        dly.push_front(t);
        v = int'(d) + off;
        if (v > 255) v = int'(d) - off;
        r = v[7:0];
        if (bad) r = r ^ 8'h80;
        drive(1'b1, t, r, clr);
        drive(1'b0, 8'($urandom), 8'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        #2;
        reset = 1'b0;
        mreset();
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b1;
    endtask

    initial begin
        int wraps;
        int prev;
        bit lk;

        mreset();
        restart();
        repeat (3) @(posedge sysclk);
        #1;
        cmp("rst_locked", locked, 0);
        cmp("rst_lat", lat, 0);
        cmp("rst_sample_cnt", sample_cnt, 0);
        cmp("rst_err_cnt", err_cnt, 0);
        cmp("rst_cnt_sat", cnt_sat, 0);
        @(negedge sysclk);
        reset = 1'b1;
        chk_on = 1'b1;

        // Lock at latency 5
        repeat (5) sample(0, 0, 0);
        #1;
        cmp("search_lat5", lat, 5);
        repeat (7) sample(0, 0, 0);
        #1;
        cmp("pre_lock", locked, 0);
        sample(0, 0, 0);
        #1;
        cmp("lock13", locked, 1);
        cmp("lock_lat", lat, 5);
        cmp("lock_sc", sample_cnt, 0);
        cmp("lock_ec", err_cnt, 0);

        // Isolated errors
        for (int i = 0; i < 100; i++) sample(0, (i == 9 || i == 49 || i == 89), 0);
        #1;
        cmp("iso_sc", sample_cnt, 100);
        cmp("iso_ec", err_cnt, 3);
        cmp("iso_locked", locked, 1);

        // Loss of lock
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        #1;
        cmp("clr_sc", sample_cnt, 0);
        cmp("clr_locked", locked, 1);
        repeat (3) sample(0, 1, 0);
        #1;
        cmp("loss3_locked", locked, 1);
        sample(0, 1, 0);
        #1;
        cmp("loss4_locked", locked, 0);
        cmp("loss4_ec", err_cnt, 4);
        cmp("loss4_sc", sample_cnt, 4);
        cmp("loss4_lat", lat, 5);
        repeat (7) sample(0, 0, 0);
        #1;
        cmp("hold_sc", sample_cnt, 4);
        cmp("hold_lat", lat, 5);
        cmp("relock_pre", locked, 0);
        sample(0, 0, 0);
        #1;
        cmp("relock", locked, 1);

        // Tolerance A: offset 2 locks cleanly
        do_reset();
        restart();
        repeat (13) sample(2, 0, 0);
        #1;
        cmp("tolA_locked", locked, 1);
        cmp("tolA_lat", lat, 5);
        repeat (30) sample(2, 0, 0);
        #1;
        cmp("tolA_ec", err_cnt, 0);
        cmp("tolA_sc", sample_cnt, 30);

        // Tolerance B: offset 3 never locks, lat keeps wrapping
        do_reset();
        restart();
        wraps = 0;
        prev = 0;
        lk = 0;
        for (int i = 0; i < 100; i++) begin
            sample(3, 0, 0);
            #1;
            if (prev == 15 && lat == 0) wraps++;
            if (locked) lk = 1;
            prev = int'(lat);
        end
        cmp("tolB_never_locked", lk, 0);
        cmp("tolB_wraps_ge3", (wraps >= 3), 1);

        // Saturation and clear
        do_reset();
        restart();
        repeat (13) sample(0, 0, 0);
        repeat (20) sample(0, 0, 0);
        #1;
        cmp("sat_sc4", sc4, 15);
        cmp("sat_flag4", sat4, 1);
        cmp("sat_sc16", sample_cnt, 20);
        cmp("sat_flag16", cnt_sat, 0);
        sample(0, 0, 1);
        #1;
        cmp("clr_sc4", sc4, 0);
        cmp("clr_sat4", sat4, 0);
        cmp("clr_locked4", locked4, 1);
        cmp("clr_sc16", sample_cnt, 0);

        // Asynchronous reset while locked
        repeat (5) sample(0, 0, 0);
        @(negedge sysclk);
        #2;
        reset = 1'b0;
        mreset();
        #1;
        cmp("arst_locked", locked, 0);
        cmp("arst_lat", lat, 0);
        cmp("arst_sc", sample_cnt, 0);
        cmp("arst_ec", err_cnt, 0);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b1;
        restart();
        repeat (12) sample(0, 0, 0);
        #1;
        cmp("arst_relock_pre", locked, 0);
        sample(0, 0, 0);
        #1;
        cmp("arst_relock", locked, 1);
        cmp("arst_relock_lat", lat, 5);

        repeat (2) @(posedge sysclk);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
